// File: rtl/cpu_mem_sequencer_pkg.sv
// Shared types and default sizing for the CPU memory sequencer.
package cpu_mem_sequencer_pkg;

    localparam int ADDR_W_DEF  = 13;
    localparam int DATA_W_DEF  = 13;
    localparam int TIMEOUT_DEF = 15;

    // Wait counter width; covers the full 1..255 timeout range.
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_DATA       = 3'd4,
        ST_DATA_WAIT  = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

endpackage

// File: rtl/cpu_mem_sequencer_timer.sv
// Wait-cycle counter shared by the fetch and data wait states.
// timeout is raised during the last allowed wait cycle if memory has not
// answered, so the FSM moves to ERROR on the same edge the count would
// reach TIMEOUT. A completion in that cycle wins over the timeout.
module mem_wait_timer
    import cpu_mem_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic done,
    output logic timeout
);

    localparam logic [TIMER_W-1:0] TERM = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt;

    // Count wait cycles, saturating at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !done && (cnt != TERM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal-count compare on the final permitted wait cycle.
    always_comb begin
        timeout = enable && !done && (cnt == LAST);
    end

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Program counter owner and fetch/load/store sequencer in front of the
// unified instruction/data memory.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | parked; waits for start
// ST_FETCH      | one-cycle instruction read strobe at pc
// ST_FETCH_WAIT | waiting for mem_done on the fetch
// ST_EXEC       | instruction held in ir; serves ls_req / ex_done
// ST_DATA       | one-cycle load or store strobe at the latched address
// ST_DATA_WAIT  | waiting for mem_done on the data access
// ST_ERROR      | memory timeout; only reset leaves
module cpu_mem_sequencer
    import cpu_mem_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              ex_done,
    input  logic              ex_branch,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_instruction,
    input  logic              mem_done
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] ir_next;
    logic [DATA_W-1:0] rdata_next;
    logic              ir_valid_next;
    logic              ls_ack_next;
    logic              write_q;
    logic              write_next;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .done    (mem_done),
        .timeout (timer_expired)
    );

    // State and datapath registers; reset is honoured mid-access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            ls_rdata  <= '0;
            ls_ack    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            write_q   <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ir        <= ir_next;
            ir_valid  <= ir_valid_next;
            ls_rdata  <= rdata_next;
            ls_ack    <= ls_ack_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            write_q   <= write_next;
        end
    end

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        addr_next       = mem_addr;
        wdata_next      = mem_wdata;
        write_next      = write_q;
        ir_next         = ir;
        ir_valid_next   = 1'b0;
        rdata_next      = ls_rdata;
        ls_ack_next     = 1'b0;
        timer_clear     = 1'b0;
        timer_en        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_instruction = 1'b0;
        busy            = 1'b1;
        timeout_err     = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_FETCH;
                    addr_next  = pc;
                end
            end

            ST_FETCH: begin
                mem_read        = 1'b1;
                mem_instruction = 1'b1;
                timer_clear     = 1'b1;
                state_next      = ST_FETCH_WAIT;
            end

            ST_FETCH_WAIT: begin
                timer_en = 1'b1;
                if (mem_done) begin
                    ir_next       = mem_rdata;
                    ir_valid_next = 1'b1;
                    state_next    = ST_EXEC;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                end
            end

            ST_EXEC: begin
                // A data request wins; a coincident ex_done is dropped.
                if (ls_req) begin
                    write_next = ls_write;
                    addr_next  = ls_addr;
                    wdata_next = ls_wdata;
                    state_next = ST_DATA;
                end else if (ex_done) begin
                    pc_next   = ex_branch ? ex_target : pc + ADDR_W'(1);
                    addr_next = pc_next;
                    state_next = halt ? ST_IDLE : ST_FETCH;
                end
            end

            ST_DATA: begin
                mem_read    = !write_q;
                mem_write   = write_q;
                timer_clear = 1'b1;
                state_next  = ST_DATA_WAIT;
            end

            ST_DATA_WAIT: begin
                timer_en = 1'b1;
                if (mem_done) begin
                    ls_ack_next = 1'b1;
                    if (!write_q) begin
                        rdata_next = mem_rdata;
                    end
                    state_next = ST_EXEC;
                end else if (timer_expired) begin
                    state_next = ST_ERROR;
                end
            end

            ST_ERROR: begin
                busy        = 1'b0;
                timeout_err = 1'b1;
            end

            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed bench for cpu_mem_sequencer with hand-computed expectations.
module tb_cpu_mem_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic        ex_done;
    logic        ex_branch;
    logic [12:0] ex_target;
    logic        ls_req;
    logic        ls_write;
    logic [12:0] ls_addr;
    logic [12:0] ls_wdata;
    logic        ls_ack;
    logic [12:0] ls_rdata;
    logic [12:0] ir;
    logic        ir_valid;
    logic [12:0] pc;
    logic        busy;
    logic        timeout_err;
    logic [12:0] mem_addr;
    logic [12:0] mem_wdata;
    logic [12:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_instruction;
    logic        mem_done;

    int tests = 0;
    int fails = 0;

    cpu_mem_sequencer #(
        .ADDR_W   (13),
        .DATA_W   (13),
        .RESET_PC (13'h0000),
        .TIMEOUT  (15)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .halt            (halt),
        .ex_done         (ex_done),
        .ex_branch       (ex_branch),
        .ex_target       (ex_target),
        .ls_req          (ls_req),
        .ls_write        (ls_write),
        .ls_addr         (ls_addr),
        .ls_wdata        (ls_wdata),
        .ls_ack          (ls_ack),
        .ls_rdata        (ls_rdata),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .pc              (pc),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_instruction (mem_instruction),
        .mem_done        (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; halt = 1'b0; ex_done = 1'b0; ex_branch = 1'b0;
        ex_target = '0; ls_req = 1'b0; ls_write = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0; mem_done = 1'b0;
        #2;
        chk("rst_pc", 16'(pc), 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_read", 16'(mem_read), 16'h0);
        chk("rst_terr", 16'(timeout_err), 16'h0);
        chk("rst_addr", 16'(mem_addr), 16'h0000);
        step(); step();
        reset = 1'b1;

        // Fetch from PC 0, memory answers one cycle after the strobe.
        start = 1'b1;
        step(); start = 1'b0;
        chk("f1_read", 16'(mem_read), 16'h1);
        chk("f1_instr", 16'(mem_instruction), 16'h1);
        chk("f1_addr", 16'(mem_addr), 16'h0000);
        chk("f1_write", 16'(mem_write), 16'h0);
        chk("f1_busy", 16'(busy), 16'h1);
        step();
        chk("f1_strobe_off", 16'(mem_read), 16'h0);
        chk("f1_irv_early", 16'(ir_valid), 16'h0);
        mem_done = 1'b1; mem_rdata = 13'h00A5;
        step(); mem_done = 1'b0;
        chk("f1_ir", 16'(ir), 16'h00A5);
        chk("f1_irv", 16'(ir_valid), 16'h1);
        step();
        chk("f1_irv_pulse", 16'(ir_valid), 16'h0);

        // Store.
        ls_req = 1'b1; ls_write = 1'b1; ls_addr = 13'h0100; ls_wdata = 13'h1234;
        step(); ls_req = 1'b0;
        chk("st_write", 16'(mem_write), 16'h1);
        chk("st_read", 16'(mem_read), 16'h0);
        chk("st_instr", 16'(mem_instruction), 16'h0);
        chk("st_addr", 16'(mem_addr), 16'h0100);
        chk("st_wdata", 16'(mem_wdata), 16'h1234);
        step();
        chk("st_write_pulse", 16'(mem_write), 16'h0);
        chk("st_ack_early", 16'(ls_ack), 16'h0);
        mem_done = 1'b1;
        step(); mem_done = 1'b0;
        chk("st_ack", 16'(ls_ack), 16'h1);
        chk("st_busy", 16'(busy), 16'h1);

        // Load right after: proves the return to EXEC.
        ls_req = 1'b1; ls_write = 1'b0; ls_addr = 13'h0200;
        step(); ls_req = 1'b0;
        chk("ld_ack_pulse", 16'(ls_ack), 16'h0);
        chk("ld_read", 16'(mem_read), 16'h1);
        chk("ld_write", 16'(mem_write), 16'h0);
        chk("ld_addr", 16'(mem_addr), 16'h0200);
        step();
        mem_done = 1'b1; mem_rdata = 13'h0777;
        step(); mem_done = 1'b0;
        chk("ld_ack", 16'(ls_ack), 16'h1);
        chk("ld_rdata", 16'(ls_rdata), 16'h0777);

        // ls_req and ex_done together: data access wins, pc unchanged.
        ls_req = 1'b1; ls_write = 1'b0; ls_addr = 13'h0010;
        ex_done = 1'b1; ex_branch = 1'b1; ex_target = 13'h0999;
        step(); ls_req = 1'b0; ex_done = 1'b0; ex_branch = 1'b0;
        chk("pri_pc", 16'(pc), 16'h0000);
        chk("pri_read", 16'(mem_read), 16'h1);
        chk("pri_addr", 16'(mem_addr), 16'h0010);
        step();
        mem_done = 1'b1; mem_rdata = 13'h0042;
        step(); mem_done = 1'b0;
        chk("pri_ack", 16'(ls_ack), 16'h1);
        chk("pri_rdata", 16'(ls_rdata), 16'h0042);
        chk("pri_pc2", 16'(pc), 16'h0000);

        // Taken branch.
        ex_done = 1'b1; ex_branch = 1'b1; ex_target = 13'h0050;
        step(); ex_done = 1'b0; ex_branch = 1'b0;
        chk("br_pc", 16'(pc), 16'h0050);
        chk("br_addr", 16'(mem_addr), 16'h0050);
        chk("br_instr", 16'(mem_instruction), 16'h1);
        step();
        mem_done = 1'b1; mem_rdata = 13'h0011;
        step(); mem_done = 1'b0;
        chk("br_ir", 16'(ir), 16'h0011);

        // Branch to the top address, then step past it: wraps to 0.
        ex_done = 1'b1; ex_branch = 1'b1; ex_target = 13'h1FFF;
        step(); ex_done = 1'b0; ex_branch = 1'b0;
        chk("top_addr", 16'(mem_addr), 16'h1FFF);
        step();
        mem_done = 1'b1;
        step(); mem_done = 1'b0;
        ex_done = 1'b1;
        step(); ex_done = 1'b0;
        chk("wrap_addr", 16'(mem_addr), 16'h0000);
        chk("wrap_pc", 16'(pc), 16'h0000);
        chk("wrap_read", 16'(mem_read), 16'h1);
        step();
        mem_done = 1'b1; mem_rdata = 13'h0022;
        step(); mem_done = 1'b0;

        // Halt at the instruction boundary.
        ex_done = 1'b1; halt = 1'b1;
        step(); ex_done = 1'b0; halt = 1'b0;
        chk("halt_busy", 16'(busy), 16'h0);
        chk("halt_pc", 16'(pc), 16'h0001);
        chk("halt_read", 16'(mem_read), 16'h0);

        // Restart; memory answers in the last allowed wait cycle.
        start = 1'b1;
        step(); start = 1'b0;
        chk("rs_addr", 16'(mem_addr), 16'h0001);
        step();
        for (int i = 0; i < 14; i++) step();
        mem_done = 1'b1; mem_rdata = 13'h0ABC;
        step(); mem_done = 1'b0;
        chk("edge_ir", 16'(ir), 16'h0ABC);
        chk("edge_irv", 16'(ir_valid), 16'h1);
        chk("edge_terr", 16'(timeout_err), 16'h0);

        // Withhold mem_done: 15 wait cycles then ERROR.
        ex_done = 1'b1;
        step(); ex_done = 1'b0;
        chk("to_pc", 16'(pc), 16'h0002);
        step();
        for (int i = 0; i < 14; i++) step();
        chk("to_busy_last", 16'(busy), 16'h1);
        chk("to_terr_last", 16'(timeout_err), 16'h0);
        step();
        chk("to_terr", 16'(timeout_err), 16'h1);
        chk("to_busy", 16'(busy), 16'h0);
        chk("to_read", 16'(mem_read), 16'h0);
        chk("to_pc_hold", 16'(pc), 16'h0002);
        start = 1'b1;
        step(); start = 1'b0;
        chk("err_start_terr", 16'(timeout_err), 16'h1);
        chk("err_start_read", 16'(mem_read), 16'h0);
        mem_done = 1'b1;
        step(); mem_done = 1'b0;
        chk("err_done_ack", 16'(ls_ack), 16'h0);
        chk("err_done_terr", 16'(timeout_err), 16'h1);
        reset = 1'b0;
        #1;
        chk("err_clr_terr", 16'(timeout_err), 16'h0);
        chk("err_clr_pc", 16'(pc), 16'h0000);
        step();
        reset = 1'b1;

        // Asynchronous reset in the middle of DATA_WAIT.
        start = 1'b1;
        step(); start = 1'b0;
        step();
        mem_done = 1'b1; mem_rdata = 13'h0321;
        step(); mem_done = 1'b0;
        chk("ar_ir", 16'(ir), 16'h0321);
        ls_req = 1'b1; ls_write = 1'b1; ls_addr = 13'h0055; ls_wdata = 13'h00AA;
        step(); ls_req = 1'b0;
        chk("ar_write", 16'(mem_write), 16'h1);
        step();
        chk("ar_busy_pre", 16'(busy), 16'h1);
        #2 reset = 1'b0;
        #1;
        chk("ar_busy", 16'(busy), 16'h0);
        chk("ar_addr", 16'(mem_addr), 16'h0000);
        chk("ar_wdata", 16'(mem_wdata), 16'h0000);
        chk("ar_rdata", 16'(ls_rdata), 16'h0000);
        chk("ar_ir0", 16'(ir), 16'h0000);
        chk("ar_write0", 16'(mem_write), 16'h0);
        #1 reset = 1'b1;
        mem_done = 1'b1;
        step(); mem_done = 1'b0;
        chk("ar_no_ack", 16'(ls_ack), 16'h0);
        chk("ar_idle", 16'(busy), 16'h0);
        step();
        chk("ar_no_ack2", 16'(ls_ack), 16'h0);
        chk("ar_no_read", 16'(mem_read), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
